// File: rtl/mc_mips_pkg.sv
// mc_mips_pkg: shared state, opcode, funct, control encodings and trap causes
// for the wait-state multi-cycle MIPS controller.
package mc_mips_pkg;
  typedef enum logic [4:0] {
    S_FETCH, S_DECODE, S_J, S_BEQ, S_BNE, S_JR, S_MEMADR, S_MEMRD, S_MEMWB,
    S_MEMWR, S_RT_EX, S_RT_WB, S_ADDI_EX, S_ADDI_WB, S_ANDI_EX, S_ANDI_WB,
    S_JAL, S_TRAP
  } state_e;
  typedef enum logic [1:0] {AC_ADD, AC_SUB, AC_FUNCT, AC_AND} alu_class_e;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_JR    = 6'b100000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b100;
  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_4    = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_IMM2 = 2'b11;
  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_JUMP   = 2'b01;
  localparam logic [1:0] PCS_ALUOUT = 2'b10;
  localparam logic [1:0] PCS_RS     = 2'b11;
  localparam logic [1:0] TC_NONE    = 2'b00;
  localparam logic [1:0] TC_ILLEGAL = 2'b01;
  localparam logic [1:0] TC_TIMEOUT = 2'b10;
  function automatic logic is_mem_state(state_e s);
    return s inside {S_FETCH, S_MEMRD, S_MEMWR};
  endfunction
endpackage

// File: rtl/mc_mips_alu_dec.sv
// mc_mips_alu_dec: maps the FSM's ALU class and the R-type funct field to
// the 3-bit ALU operation.
module mc_mips_alu_dec
  import mc_mips_pkg::*;
(
  input  logic [1:0] alu_class_i,
  input  logic [5:0] funct_i,
  output logic [2:0] alu_operation_o
);
  logic [2:0] fn_op;
  assign fn_op = funct_i == F_AND ? ALU_AND :
                 funct_i == F_OR  ? ALU_OR  :
                 funct_i == F_SUB ? ALU_SUB :
                 funct_i == F_SLT ? ALU_SLT : ALU_ADD;
  assign alu_operation_o = alu_class_i == AC_SUB   ? ALU_SUB :
                           alu_class_i == AC_AND   ? ALU_AND :
                           alu_class_i == AC_FUNCT ? fn_op   : ALU_ADD;
endmodule

// File: rtl/mc_mips_ctrl_wait.sv
// mc_mips_ctrl_wait: multi-cycle MIPS controller with mem_ack wait states,
// bounded wait timeout and trap state; MC_MIPS_INSTRET_EN adds a retired count.
module mc_mips_ctrl_wait
  import mc_mips_pkg::*;
#(
  parameter int TMO_W   = 4,
  parameter int TMO_MAX = 15,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ack,
  output logic             iord,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             reg_dst,
  output logic             last_reg,
  output logic             mem_to_reg,
  output logic             pc_to_reg,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic             pc_load,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       pc_src,
  output logic [2:0]       alu_operation,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic [CNT_W-1:0] instret
);
  state_e           state_q, state_d;
  logic [TMO_W-1:0] cnt_q, cnt_d;
  logic [1:0]       cause_q, cause_d;
  logic             trap_q;
  logic             waiting, timeout, pc_write, beq, bne;
  alu_class_e       alu_class;
  logic [2:0]       alu_op;
  always_comb begin
    waiting = is_mem_state(state_q) && !mem_ack;
    timeout = waiting && cnt_q == TMO_W'(TMO_MAX - 1);
    cnt_d   = waiting ? cnt_q + TMO_W'(1) : '0;
    state_d = state_q;
    cause_d = cause_q;
    case (state_q)
      S_FETCH:   state_d = mem_ack ? S_DECODE : S_FETCH;
      S_DECODE:
        case (opcode)
          OP_J:         state_d = S_J;
          OP_BEQ:       state_d = S_BEQ;
          OP_BNE:       state_d = S_BNE;
          OP_JR:        state_d = S_JR;
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_RT_EX;
          OP_ADDI:      state_d = S_ADDI_EX;
          OP_ANDI:      state_d = S_ANDI_EX;
          OP_JAL:       state_d = S_JAL;
          default: begin
            state_d = S_TRAP;
            cause_d = TC_ILLEGAL;
          end
        endcase
      S_MEMADR:  state_d = opcode == OP_SW ? S_MEMWR : S_MEMRD;
      S_MEMRD:   state_d = mem_ack ? S_MEMWB : S_MEMRD;
      S_MEMWR:   state_d = mem_ack ? S_FETCH : S_MEMWR;
      S_RT_EX:   state_d = S_RT_WB;
      S_ADDI_EX: state_d = S_ADDI_WB;
      S_ANDI_EX: state_d = S_ANDI_WB;
      S_TRAP:    state_d = S_TRAP;
      default:   state_d = S_FETCH;
    endcase
    // an ack in the final allowed wait cycle has already cleared waiting
    if (timeout) begin
      state_d = S_TRAP;
      cause_d = TC_TIMEOUT;
    end
  end
  always_comb begin
    {iord, mem_read, mem_write, ir_write, reg_dst, last_reg} = '0;
    {mem_to_reg, pc_to_reg, reg_write, alu_src_a, pc_write, beq, bne} = '0;
    alu_src_b = SRCB_REG;
    pc_src    = PCS_ALU;
    alu_class = AC_ADD;
    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_4;
        ir_write  = mem_ack;
        pc_write  = mem_ack;
      end
      S_DECODE:  alu_src_b = SRCB_IMM2;
      S_J:       {pc_src, pc_write} = {PCS_JUMP, 1'b1};
      S_BEQ:     {alu_src_a, alu_class, pc_src, beq} = {1'b1, AC_SUB, PCS_ALUOUT, 1'b1};
      S_BNE:     {alu_src_a, alu_class, pc_src, bne} = {1'b1, AC_SUB, PCS_ALUOUT, 1'b1};
      S_JR:      {pc_src, pc_write} = {PCS_RS, 1'b1};
      S_MEMADR:  {alu_src_a, alu_src_b} = {1'b1, SRCB_IMM};
      S_MEMRD:   {iord, mem_read} = 2'b11;
      S_MEMWB:   {mem_to_reg, reg_write} = 2'b11;
      S_MEMWR:   {iord, mem_write} = 2'b11;
      S_RT_EX:   {alu_src_a, alu_class} = {1'b1, AC_FUNCT};
      S_RT_WB:   {reg_dst, reg_write} = 2'b11;
      S_ADDI_EX: {alu_src_a, alu_src_b} = {1'b1, SRCB_IMM};
      S_ANDI_EX: {alu_src_a, alu_src_b, alu_class} = {1'b1, SRCB_IMM, AC_AND};
      S_ADDI_WB, S_ANDI_WB: reg_write = 1'b1;
      S_JAL: begin
        {pc_write, pc_to_reg, last_reg, reg_write} = 4'b1111;
        pc_src = PCS_JUMP;
      end
      default: ;
    endcase
  end
  mc_mips_alu_dec u_alu_dec (
    .alu_class_i    (alu_class),
    .funct_i        (funct),
    .alu_operation_o(alu_op)
  );
  assign alu_operation = state_q == S_TRAP ? 3'b000 : alu_op;
  assign pc_load       = pc_write | (beq & zero) | (bne & ~zero);
  assign trap          = trap_q;
  assign trap_cause    = cause_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
      trap_q  <= 1'b0;
      cause_q <= TC_NONE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      trap_q  <= state_d == S_TRAP;
      cause_q <= cause_d;
    end
  end
`ifdef MC_MIPS_INSTRET_EN
  logic [CNT_W-1:0] instret_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) instret_q <= '0;
    else if (state_d == S_FETCH && state_q != S_FETCH) instret_q <= instret_q + CNT_W'(1);
  end
  assign instret = instret_q;
`else
  assign instret = '0;
`endif
endmodule

// File: tb/tb_mc_mips_ctrl_wait.sv
// tb_mc_mips_ctrl_wait: directed and randomized instruction streams checked
// cycle by cycle against an instruction-level model of the controller.
module tb_mc_mips_ctrl_wait;
  localparam logic [2:0] A_AND = 3'b000, A_OR = 3'b001, A_ADD = 3'b010,
                         A_SUB = 3'b011, A_SLT = 3'b100;
  logic        clk = 1'b0, rst = 1'b1, zero = 1'b0, mem_ack = 1'b0;
  logic [5:0]  opcode = '0, funct = '0;
  logic        iord, mem_read, mem_write, ir_write, reg_dst, last_reg;
  logic        mem_to_reg, pc_to_reg, reg_write, alu_src_a, pc_load, trap;
  logic [1:0]  alu_src_b, pc_src, trap_cause;
  logic [2:0]  alu_operation;
  logic [31:0] instret;
  int          checks = 0, passes = 0, fails = 0;
  logic [31:0] exp_ir = '0;
  logic [20:0] obs;
  always #5 clk = ~clk;
  mc_mips_ctrl_wait dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ack(mem_ack), .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .reg_dst(reg_dst), .last_reg(last_reg),
    .mem_to_reg(mem_to_reg), .pc_to_reg(pc_to_reg), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .pc_load(pc_load), .alu_src_b(alu_src_b),
    .pc_src(pc_src), .alu_operation(alu_operation), .trap(trap),
    .trap_cause(trap_cause), .instret(instret)
  );
  assign obs = {iord, mem_read, mem_write, ir_write, reg_dst, last_reg, mem_to_reg,
                pc_to_reg, reg_write, alu_src_a, pc_load, alu_src_b, pc_src,
                alu_operation, trap, trap_cause};
  // flags: iord,mem_read,mem_write,ir_write,reg_dst,last_reg,mem_to_reg,pc_to_reg,reg_write,alu_src_a
  function automatic logic [20:0] v(input logic [9:0] f, input logic pl, input logic [1:0] sb,
                                    input logic [1:0] ps, input logic [2:0] alu, input logic [2:0] tr);
    return {f, pl, sb, ps, alu, tr};
  endfunction
  function automatic logic [2:0] ralu(input logic [5:0] fn);
    case (fn)
      6'b100100: return A_AND;
      6'b100101: return A_OR;
      6'b100010: return A_SUB;
      6'b101010: return A_SLT;
      default:   return A_ADD;
    endcase
  endfunction
  function automatic logic [31:0] ir_exp();
`ifdef MC_MIPS_INSTRET_EN
    return exp_ir;
`else
    return 32'd0;
`endif
  endfunction
  function automatic logic rb();
    return 1'($urandom);
  endfunction
  function automatic logic [20:0] v_fwait();
    return v(10'b0100000000, 1'b0, 2'b01, 2'b00, A_ADD, 3'b000);
  endfunction
  function automatic logic [20:0] v_fack();
    return v(10'b0101000000, 1'b1, 2'b01, 2'b00, A_ADD, 3'b000);
  endfunction
  function automatic logic [20:0] v_dec();
    return v(10'b0, 1'b0, 2'b11, 2'b00, A_ADD, 3'b000);
  endfunction
  function automatic logic [20:0] v_madr();
    return v(10'b0000000001, 1'b0, 2'b10, 2'b00, A_ADD, 3'b000);
  endfunction
  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask
  // entered just after a rising edge; checks at the falling edge
  task automatic cyc(input logic ack, input logic [20:0] e, input string tag);
    mem_ack = ack;
    @(negedge clk);
    chk(tag, 32'(obs), 32'(e));
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    mem_ack = 1'b0;
    #1;
    exp_ir = '0;
    chk("rst_ctl", 32'(obs), 32'(v_fwait()));
    chk("rst_instret", instret, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                           input int fw, input int mw);
    logic [20:0] e;
    opcode = op;
    funct  = fn;
    zero   = z;
    repeat (fw) cyc(1'b0, v_fwait(), "fetch_wait");
    cyc(1'b1, v_fack(), "fetch_ack");
    cyc(rb(), v_dec(), "decode");
    case (op)
      6'd2:  cyc(rb(), v(10'b0, 1'b1, 2'b00, 2'b01, A_ADD, 3'b0), "j");
      6'd4:  cyc(rb(), v(10'b1, z, 2'b00, 2'b10, A_SUB, 3'b0), "beq");
      6'd5:  cyc(rb(), v(10'b1, !z, 2'b00, 2'b10, A_SUB, 3'b0), "bne");
      6'd32: cyc(rb(), v(10'b0, 1'b1, 2'b00, 2'b11, A_ADD, 3'b0), "jr");
      6'd35, 6'd43: begin
        cyc(rb(), v_madr(), "memadr");
        e = op == 6'd35 ? v(10'b1100000000, 1'b0, 2'b00, 2'b00, A_ADD, 3'b0)
                        : v(10'b1010000000, 1'b0, 2'b00, 2'b00, A_ADD, 3'b0);
        repeat (mw) cyc(1'b0, e, "mem_wait");
        cyc(1'b1, e, "mem_ack");
        if (op == 6'd35) cyc(rb(), v(10'b0000001010, 1'b0, 2'b00, 2'b00, A_ADD, 3'b0), "memwb");
      end
      6'd0: begin
        cyc(rb(), v(10'b1, 1'b0, 2'b00, 2'b00, ralu(fn), 3'b0), "rt_ex");
        cyc(rb(), v(10'b0000100010, 1'b0, 2'b00, 2'b00, A_ADD, 3'b0), "rt_wb");
      end
      6'd8, 6'd12: begin
        cyc(rb(), v(10'b1, 1'b0, 2'b10, 2'b00, op == 6'd8 ? A_ADD : A_AND, 3'b0), "imm_ex");
        cyc(rb(), v(10'b10, 1'b0, 2'b00, 2'b00, A_ADD, 3'b0), "imm_wb");
      end
      6'd3: cyc(rb(), v(10'b0000010110, 1'b1, 2'b00, 2'b01, A_ADD, 3'b0), "jal");
      default: ;
    endcase
    exp_ir++;
    chk("instret", instret, ir_exp());
  endtask
  initial begin
    logic [5:0] ops[10] = '{6'd0, 6'd2, 6'd3, 6'd4, 6'd5, 6'd8, 6'd12, 6'd32, 6'd35, 6'd43};
    logic [5:0] fns[6]  = '{6'b100000, 6'b100100, 6'b100101, 6'b100010, 6'b101010, 6'b111111};
    do_reset();
    run_instr(6'd0, 6'b100000, 1'b0, 0, 0);
    run_instr(6'd35, 6'd0, 1'b0, 3, 2);
    run_instr(6'd4, 6'd0, 1'b1, 0, 0);
    run_instr(6'd5, 6'd0, 1'b1, 0, 0);
    do_reset();
    run_instr(6'd2, 6'd0, 1'b0, 1, 0);
    run_instr(6'd8, 6'd0, 1'b0, 0, 0);
    run_instr(6'd3, 6'd0, 1'b0, 2, 0);
    chk("instret_three", instret, ir_exp());
    opcode = 6'd35;
    cyc(1'b1, v_fack(), "fetch_ack");
    cyc(rb(), v_dec(), "decode");
    cyc(rb(), v_madr(), "memadr");
    repeat (2) cyc(1'b0, v(10'b1100000000, 1'b0, 2'b00, 2'b00, A_ADD, 3'b0), "memrd_wait");
    do_reset();
    opcode = 6'h3F;
    cyc(1'b1, v_fack(), "fetch_ack");
    cyc(rb(), v_dec(), "decode");
    repeat (20) cyc(rb(), v(10'b0, 1'b0, 2'b00, 2'b00, 3'b000, 3'b101), "trap_illegal");
    do_reset();
    opcode = 6'd43;
    cyc(1'b1, v_fack(), "fetch_ack");
    cyc(rb(), v_dec(), "decode");
    cyc(rb(), v_madr(), "memadr");
    repeat (15) cyc(1'b0, v(10'b1010000000, 1'b0, 2'b00, 2'b00, A_ADD, 3'b0), "sw_wait");
    repeat (3) cyc(rb(), v(10'b0, 1'b0, 2'b00, 2'b00, 3'b000, 3'b110), "trap_tmo");
    chk("tmo_instret", instret, ir_exp());
    do_reset();
    repeat (15) cyc(1'b0, v_fwait(), "fetch_wait_tmo");
    cyc(rb(), v(10'b0, 1'b0, 2'b00, 2'b00, 3'b000, 3'b110), "fetch_tmo");
    do_reset();
    run_instr(6'd43, 6'd0, 1'b0, 14, 14);
    run_instr(6'd35, 6'd0, 1'b0, 14, 14);
    for (int i = 0; i < 60; i++)
      run_instr(ops[$urandom_range(0, 9)], fns[$urandom_range(0, 5)], rb(),
                int'($urandom_range(0, 4)), int'($urandom_range(0, 4)));
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
